// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the byte-serial carry-lookahead adder.
package cla_seq_pkg;
  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
endpackage

// File: rtl/cla_seq_adder32_if.sv
// Request/result bundle of cla_seq_adder32; the slave side is the adder.
interface cla_seq_adder32_if
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NBYTES*BYTE_W-1:0] a;
  logic [NBYTES*BYTE_W-1:0] b;
  logic                     cin;
  logic                     sub;
  logic                     out_valid;
  logic                     out_ready;
  logic [NBYTES*BYTE_W-1:0] sum;
  logic                     cout;
  logic                     ovf;
  logic                     busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_seq_adder32_fcla8.sv
// fcla8: 8-bit carry-lookahead adder exporting group generate/propagate.
module fcla8
  import cla_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              g_o,
  output logic              p_o
);
  logic [BYTE_W-1:0] gen;
  logic [BYTE_W-1:0] prop;
  logic [BYTE_W-1:0] carry;
  logic              run_g;
  logic              run_p;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Every carry is formed from the running group G/P and cin_i, never rippled.
  // NOTE: blocking '=' here; run_g/run_p are scratch values consumed in the same pass.
  always_comb begin
    run_g    = 1'b0;
    run_p    = 1'b1;
    carry    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < BYTE_W; i++) begin
      run_g = gen[i] | (prop[i] & run_g);
      run_p = run_p & prop[i];
      if (i < BYTE_W - 1) carry[i+1] = run_g | (run_p & cin_i);
    end
    sum_o = prop ^ carry;
    g_o   = run_g;
    p_o   = run_p;
  end
endmodule

// File: rtl/cla_seq_adder32.sv
// Byte-serial adder/subtractor: one fcla8 pass per cycle, LSB byte first.
module cla_seq_adder32
  import cla_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_seq_adder32_if.slave   bus
);
  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = $clog2(NBYTES);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [BYTE_W-1:0]  byte_a;
  logic [BYTE_W-1:0]  byte_b;
  logic [BYTE_W-1:0]  byte_sum;
  logic               grp_g;
  logic               grp_p;
  logic               last_byte;

  assign byte_a    = a_q[idx_q*BYTE_W +: BYTE_W];
  assign byte_b    = b_q[idx_q*BYTE_W +: BYTE_W];
  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  fcla8 u_fcla8 (
    .a_i   (byte_a),
    .b_i   (byte_b),
    .cin_i (carry_q),
    .sum_o (byte_sum),
    .g_o   (grp_g),
    .p_o   (grp_p)
  );

  // NOTE: sequential state uses '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every next-state value gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1, so cin is overridden by sub.
          a_d     = bus.a;
          b_d     = bus.b ^ {W{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = byte_sum;
        carry_d = grp_g | (grp_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (last_byte) begin
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (byte_sum[BYTE_W-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/cla_seq_adder32.md
CLA_SEQ_ADDER32 -- requirements
Module: cla_seq_adder32

Interface
REQ-001 SHALL have parameter NBYTES, default 4, operand width in bytes (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  8*NBYTES  operand A.
REQ-007 SHALL have port b  input  8*NBYTES  operand B.
REQ-008 SHALL have port cin  input  1  carry-in (ignored when sub=1).
REQ-009 SHALL have port sub  input  1  1 = compute A-B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  8*NBYTES  result.
REQ-013 SHALL have port cout  output  1  carry out of MSB.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow.
REQ-015 SHALL have port busy  output  1  high in any non-IDLE state.

Function
REQ-016 SHALL add one byte per cycle through a single 8-bit carry-lookahead adder, LSB byte first.
REQ-017 SHALL use a three-state FSM: IDLE, ADD, DONE.
REQ-018 IDLE: in_ready=1; on in_valid=1 SHALL latch a, b XOR {sub replicated}, carry=(sub ? 1 : cin), byte index=0, go to ADD.
REQ-019 ADD: each cycle SHALL drive adder with operand byte[idx] and carry register, write Sum into sum byte[idx], set carry = G | (P & carry), increment idx.
REQ-020 ADD SHALL go to DONE on the cycle idx==NBYTES-1 completes; latency from accept edge to out_valid=1 is exactly NBYTES cycles.
REQ-021 DONE: out_valid=1, sum/cout/ovf stable; on out_ready=1 SHALL go to IDLE next edge.
REQ-022 in_ready SHALL be 1 only in IDLE; in_valid in ADD/DONE SHALL be ignored, no queuing.
REQ-023 cout SHALL be final carry register; for sub=1, cout=1 means no borrow.
REQ-024 ovf SHALL be (a_msb == b'_msb) & (sum_msb != a_msb), b' = latched (possibly inverted) B.
REQ-025 Arithmetic SHALL wrap modulo 2^(8*NBYTES); no saturation.
REQ-026 sum, cout, ovf SHALL hold last value until next DONE; they are defined only while out_valid=1.
REQ-027 in_valid and out_ready SHALL never produce same-edge DONE->ADD; a new request needs an IDLE cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
REQ-029 Reset asserted mid-ADD or in DONE SHALL abort the operation; no partial result is ever presented with out_valid=1.
REQ-030 Operation SHALL resume on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package cla_seq_pkg SHALL hold the state enum (IDLE, ADD, DONE), BYTE_W=8, and default NBYTES.
REQ-032 The one sub-module SHALL be fcla8 (8-bit CLA with G/P outputs), instantiated once; no other adders.
REQ-033 Operand shift/index registers, carry register and FSM SHALL be in cla_seq_adder32 itself.

Verification
REQ-034 a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0100, cout=0, ovf=0.
REQ-035 a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, ovf=0; a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1.
REQ-036 sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0; a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, ovf=1.
REQ-037 out_ready held low 10 cycles -> out_valid stays 1, sum stable, in_ready 0; second in_valid during that time ignored.
REQ-038 rst_n pulsed low at 2nd ADD cycle -> all outputs reset value at once, out_valid never rises, next request completes correctly.
REQ-039 Random 10k back-to-back ops, random out_ready -> sum/cout/ovf match reference model, latency exactly NBYTES.
